branch_history_table: RTL
=========================

// Module: branch_history_table
// PURPOSE
//  IF-stage branch predictor upstream of the fetch PC mux. Holds 2^INDEX_W 2-bit saturating
//  counters indexed by PC[INDEX_W+1:2]. Combinationally predicts conditional branches seen in
//  IF (drives fetch IFBranch), carries the prediction to ID alongside the IF/ID register, and
//  trains on branch outcomes resolved in ID. Clear FSM initialises the table after reset.
// PARAMETERS
//  INDEX_W     6      table index width; 2^INDEX_W entries
//  INIT_STATE  2'b01  counter value written by clear sweep (weakly not-taken)
// PORTS
//  clock           in   1   single clock; all state updates on rising edge
//  reset           in   1   synchronous, active-high
//  if_pc           in   32  PC of instruction currently in IF (byte address)
//  if_instruction  in   32  instruction word fetched from ROM
//  if_advance      in   1   IF->ID transfer this cycle (PCWrite & ~ex_stall)
//  if_flush        in   1   squash the IF/ID slot (mispredict, jump, eret)
//  pred_taken      out  1   IF prediction -> fetch IFBranch (combinational)
//  id_pred_taken   out  1   registered prediction for the instruction now in ID
//  upd_valid       in   1   ID resolved a conditional branch this cycle
//  upd_pc          in   32  PC of the resolved branch
//  upd_taken       in   1   actual outcome
//  id_mispredict   out  1   upd_valid & (upd_taken != id_pred_taken), combinational
//  busy            out  1   clear sweep in progress
// BEHAVIOUR
//  - Branch decode: op=000100 beq, 000101 bne, 000110 blez, 000111 bgtz, 000001 REGIMM
//    (bltz/bgez/bltzal/bgezal); all other opcodes are non-branch.
//  - pred_taken = ~busy & is_branch(if_instruction) & ctr[if_pc idx][1]. Zero-latency read.
//  - FSM: CLEAR -> RUN. reset (any state, mid-sweep included) -> CLEAR, clr_idx=0.
//    CLEAR: ctr[clr_idx]<=INIT_STATE, clr_idx++ each cycle; after writing entry
//    2^INDEX_W-1 -> RUN. Sweep = 2^INDEX_W cycles; busy=1 throughout, 0 in RUN.
//  - Reset values: busy=1, id_pred_taken=0, stats counters=0; pred_taken=0 while busy.
//  - id_pred_taken: reset or if_flush -> 0 (flush wins over advance); else if_advance ->
//    pred_taken; else hold (stall).
//  - Update (RUN only, upd_valid=1): idx=upd_pc[INDEX_W+1:2]; taken: ctr+1 saturating at
//    2'b11; not taken: ctr-1 saturating at 2'b00. Updates during CLEAR are dropped.
//  - Same-cycle lookup and update to one index: lookup returns pre-update value (no bypass);
//    new value visible next cycle. Aliasing across PCs is permitted (untagged).
//  - id_mispredict is informational; the PC redirect (nBranch) is generated in ID.
// CONFIGURATION
//  BHT_STATS_EN defined: adds outputs stat_branches[31:0] (+1 per accepted upd_valid) and
//  stat_mispredicts[31:0] (+1 when id_mispredict on an accepted update); both reset to 0,
//  saturate at 32'hFFFF_FFFF. Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 reset 1 cycle, release -> busy=1 for exactly 64 cycles, then 0; pred_taken=0 while busy.
//  2 after clear, if_pc=0x40, beq word 0x1000_0003 -> pred_taken=0; 2x upd_valid,
//    upd_pc=0x40, upd_taken=1 -> ctr=11, pred_taken=1; add word 0x0000_0020 at 0x40 -> 0.
//  3 ctr=11, 3 more taken updates -> stays 11; 4 not-taken -> 10,01,00,00 (pred 1,0,0,0).
//  4 lookup+update same idx same cycle (ctr=01, taken) -> pred_taken=0 that cycle, 1 next.
//  5 pred_taken=1, if_advance=0 2 cycles -> id_pred_taken holds; if_advance=1 & if_flush=1 -> 0;
//    upd_taken=0 with id_pred_taken=1 -> id_mispredict=1.
//  6 reset asserted mid-sweep (clr_idx=30) -> restarts at 0, busy 64 more cycles; with
//    BHT_STATS_EN, 5 updates/2 mispredicts -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/branch_history_table.sv
// IF-stage branch predictor: 2^INDEX_W untagged 2-bit saturating counters, cleared by a sweep after reset.
// Optional statistics outputs are enabled with the BHT_STATS_EN macro.
module branch_history_table #(
    parameter int         INDEX_W    = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        if_advance,
    input  logic        if_flush,
    output logic        pred_taken,
    output logic        id_pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        id_mispredict,
`ifdef BHT_STATS_EN
    output logic        busy,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`else
    output logic        busy
`endif
);

    // state    | meaning
    // ST_CLEAR | sweeping INIT_STATE into every counter, one entry per cycle
    // ST_RUN   | predicting and training
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam int ENTRIES = 1 << INDEX_W;

    state_t             state;
    state_t             state_next;
    logic [INDEX_W-1:0] clr_idx;
    logic [1:0]         ctr [ENTRIES];
    logic [INDEX_W-1:0] if_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic [1:0]         if_ctr;
    logic [1:0]         upd_ctr;
    logic [1:0]         upd_ctr_next;
    logic               is_branch;
    logic               upd_accept;
    logic               unused_bits;

    assign if_idx      = if_pc[INDEX_W+1:2];
    assign upd_idx     = upd_pc[INDEX_W+1:2];
    assign if_ctr      = ctr[if_idx];
    assign upd_ctr     = ctr[upd_idx];
    assign unused_bits = ^{if_pc[31:INDEX_W+2], if_pc[1:0], if_instruction[25:0],
                           upd_pc[31:INDEX_W+2], upd_pc[1:0]};

    always_comb begin
        case (if_instruction[31:26])
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: is_branch = 1'b1;
            default:                                               is_branch = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (&clr_idx) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (busy) clr_idx <= clr_idx + 1'b1;
        end
    end

    assign pred_taken    = ~busy & is_branch & if_ctr[1];
    assign id_mispredict = upd_valid & (upd_taken != id_pred_taken);
    assign upd_accept    = upd_valid & ~busy;

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'd1;
        end
    end

    // Table has no reset of its own; the sweep provides initialisation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (busy)            ctr[clr_idx] <= INIT_STATE;
            else if (upd_accept) ctr[upd_idx] <= upd_ctr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || if_flush) id_pred_taken <= 1'b0;
        else if (if_advance)   id_pred_taken <= pred_taken;
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_accept) begin
            if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (id_mispredict && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
